// File: rtl/bounce_pkg.sv
// ============================================================================
// bounce_pkg : shared state and direction encodings for the 2-D bounce core
// Rev 1.0
// ============================================================================
`default_nettype none

package bounce_pkg;

    typedef enum logic [1:0] {
        FALL = 2'd0,
        RISE = 2'd1,
        REST = 2'd2
    } state_t;

    localparam logic c_DIR_RIGHT = 1'b0;
    localparam logic c_DIR_LEFT  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// tick_gen : motion-tick divider with pause hold and synchronous clear
// Rev 1.0
// ============================================================================
`default_nettype none

module tick_gen #(
    parameter int TICK_DIV = 8311680
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_pause,
    output logic o_tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == c_LAST);
    assign o_tick = w_wrap && !i_pause;

    always_ff @(posedge clk) begin
        if (!i_rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (!i_pause) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bounce2d_param.sv
// ============================================================================
// bounce2d_param : 2-D ball centre under gravity with damped floor bounces,
//                  ceiling clamp, wall reflection, rest, relaunch and pause
// Rev 1.0
// ============================================================================
`default_nettype none

module bounce2d_param
    import bounce_pkg::*;
#(
    parameter int W          = 11,
    parameter int V_W        = 6,
    parameter int TICK_DIV   = 8311680,
    parameter int X_MIN      = 8,
    parameter int X_MAX      = 1000,
    parameter int Y_MIN      = 0,
    parameter int Y_FLOOR    = 500,
    parameter int X_INIT     = 504,
    parameter int Y_INIT     = 0,
    parameter int VX         = 2,
    parameter int VY_INIT    = 1,
    parameter int GRAVITY    = 1,
    parameter int DAMP_SHIFT = 1,
    parameter int LAUNCH_V   = 40
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         launch,
    input  logic         pause,
    output logic [W-1:0] center_x,
    output logic [W-1:0] center_y,
    output logic         at_rest,
    output logic         floor_hit,
    output logic         wall_hit
);

    localparam int S_W = W + 1;
    localparam logic [S_W-1:0] c_Y_FLOOR_E = S_W'(Y_FLOOR);
    localparam logic [S_W-1:0] c_Y_MIN_E   = S_W'(Y_MIN);
    localparam logic [S_W-1:0] c_X_MAX_E   = S_W'(X_MAX);
    localparam logic [S_W-1:0] c_X_MIN_E   = S_W'(X_MIN);
    localparam logic [S_W-1:0] c_VX_E      = S_W'(VX);
    localparam logic [V_W:0]   c_GRAV_E    = (V_W+1)'(GRAVITY);
    localparam logic [V_W-1:0] c_GRAV      = V_W'(GRAVITY);

    state_t         r_state, w_state_nxt;
    logic [W-1:0]   r_x, r_y, w_x_nxt, w_y_nxt, w_y_sub;
    logic [V_W-1:0] r_vy, w_vy_nxt, w_vy_sat, w_vy_damp;
    logic           r_dir, w_dir_nxt;
    logic           r_floor_hit, r_wall_hit, w_floor, w_wall;
    logic           w_tick;
    logic [S_W-1:0] w_y_ext, w_x_ext, w_fall_sum, w_rise_lim;
    logic [V_W:0]   w_vy_inc;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (CLK),
        .i_rst_n (RESET_N),
        .i_clr   (launch),
        .i_pause (pause),
        .o_tick  (w_tick)
    );

    // Widened sums so boundary tests never see a wrapped coordinate
    assign w_y_ext    = {1'b0, r_y};
    assign w_x_ext    = {1'b0, r_x};
    assign w_fall_sum = w_y_ext + S_W'(r_vy);
    assign w_rise_lim = c_Y_MIN_E + S_W'(r_vy);
    assign w_y_sub    = r_y - W'(r_vy);
    assign w_vy_inc   = {1'b0, r_vy} + c_GRAV_E;
    assign w_vy_sat   = w_vy_inc[V_W] ? {V_W{1'b1}} : w_vy_inc[V_W-1:0];
    assign w_vy_damp  = r_vy >> DAMP_SHIFT;

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_vy_nxt    = r_vy;
        w_dir_nxt   = r_dir;
        w_floor     = 1'b0;
        w_wall      = 1'b0;
        if (launch) begin
            w_vy_nxt    = V_W'(LAUNCH_V);
            w_state_nxt = RISE;
        end else if (w_tick) begin
            case (r_state)
                FALL: begin
                    if (w_fall_sum >= c_Y_FLOOR_E) begin
                        w_y_nxt  = W'(Y_FLOOR);
                        w_vy_nxt = w_vy_damp;
                        w_floor  = 1'b1;
                        if (w_vy_damp == '0) w_state_nxt = REST;
                        else                 w_state_nxt = RISE;
                    end else begin
                        w_y_nxt  = w_fall_sum[W-1:0];
                        w_vy_nxt = w_vy_sat;
                    end
                end
                RISE: begin
                    if (w_y_ext < w_rise_lim) begin
                        w_y_nxt     = W'(Y_MIN);
                        w_vy_nxt    = '0;
                        w_state_nxt = FALL;
                    end else if ({1'b0, r_vy} <= c_GRAV_E) begin
                        w_y_nxt     = w_y_sub;
                        w_vy_nxt    = '0;
                        w_state_nxt = FALL;
                    end else begin
                        w_y_nxt  = w_y_sub;
                        w_vy_nxt = r_vy - c_GRAV;
                    end
                end
                default: ;
            endcase
            // A tick that lands the ball in REST freezes x as well
            if (w_state_nxt != REST) begin
                if (r_dir == c_DIR_RIGHT) begin
                    if (w_x_ext + c_VX_E >= c_X_MAX_E) begin
                        w_x_nxt   = W'(X_MAX);
                        w_dir_nxt = c_DIR_LEFT;
                        w_wall    = 1'b1;
                    end else begin
                        w_x_nxt = r_x + W'(VX);
                    end
                end else begin
                    if (w_x_ext < c_X_MIN_E + c_VX_E) begin
                        w_x_nxt   = W'(X_MIN);
                        w_dir_nxt = c_DIR_RIGHT;
                        w_wall    = 1'b1;
                    end else begin
                        w_x_nxt = r_x - W'(VX);
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state     <= FALL;
            r_x         <= W'(X_INIT);
            r_y         <= W'(Y_INIT);
            r_vy        <= V_W'(VY_INIT);
            r_dir       <= c_DIR_RIGHT;
            r_floor_hit <= 1'b0;
            r_wall_hit  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_vy        <= w_vy_nxt;
            r_dir       <= w_dir_nxt;
            r_floor_hit <= w_floor;
            r_wall_hit  <= w_wall;
        end
    end

    assign center_x  = r_x;
    assign center_y  = r_y;
    assign at_rest   = (r_state == REST);
    assign floor_hit = r_floor_hit;
    assign wall_hit  = r_wall_hit;

endmodule

`default_nettype wire

// File: tb/tb_bounce2d_param.sv
// ============================================================================
// tb_bounce2d_param : directed bench for bounce2d_param with a per-cycle model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bounce2d_param;

    localparam int TD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, launch, pause, lo;
    assign lo = 1'b0;

    logic [10:0] ax, ay, bx, by, cx, cy;
    logic a_rest, a_fh, a_wh, b_rest, b_fh, b_wh, c_rest, c_fh, c_wh;

    bounce2d_param #(.TICK_DIV(TD), .VX(0)) u_a (
        .CLK(clk), .RESET_N(rst_n), .launch(launch), .pause(pause),
        .center_x(ax), .center_y(ay), .at_rest(a_rest), .floor_hit(a_fh), .wall_hit(a_wh));

    bounce2d_param #(.TICK_DIV(TD), .VX(2), .X_INIT(996), .VY_INIT(0), .Y_INIT(500)) u_b (
        .CLK(clk), .RESET_N(rst_n), .launch(lo), .pause(lo),
        .center_x(bx), .center_y(by), .at_rest(b_rest), .floor_hit(b_fh), .wall_hit(b_wh));

    bounce2d_param #(.TICK_DIV(TD), .VX(2), .X_INIT(996), .VY_INIT(0), .Y_INIT(0)) u_c (
        .CLK(clk), .RESET_N(rst_n), .launch(lo), .pause(lo),
        .center_x(cx), .center_y(cy), .at_rest(c_rest), .floor_hit(c_fh), .wall_hit(c_wh));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model of DUT A (VX=0, defaults otherwise); st: 0 falling, 1 rising, 2 resting
    int m_x, m_y, m_vy, m_dir, m_st, m_cnt, m_ticks, m_fh, m_wh;
    int m_valid = 0;
    int ny, nv, ns;
    localparam int M_VX = 0;

    always @(posedge clk) begin
        m_fh = 0;
        m_wh = 0;
        if (!rst_n) begin
            m_x = 504; m_y = 0; m_vy = 1; m_dir = 0; m_st = 0;
            m_cnt = 0; m_ticks = 0; m_valid = 1;
        end else if (launch) begin
            m_vy = 40; m_st = 1; m_cnt = 0;
        end else if (!pause) begin
            if (m_cnt != TD - 1) begin
                m_cnt++;
            end else begin
                m_cnt = 0;
                m_ticks++;
                ny = m_y; nv = m_vy; ns = m_st;
                if (m_st == 0) begin
                    if (m_y + m_vy >= 500) begin
                        ny = 500; nv = m_vy / 2; m_fh = 1; ns = (nv == 0) ? 2 : 1;
                    end else begin
                        ny = m_y + m_vy; nv = (m_vy + 1 > 63) ? 63 : m_vy + 1;
                    end
                end else if (m_st == 1) begin
                    if (m_y < m_vy)       begin ny = 0;          nv = 0;        ns = 0; end
                    else if (m_vy <= 1)   begin ny = m_y - m_vy; nv = 0;        ns = 0; end
                    else                  begin ny = m_y - m_vy; nv = m_vy - 1;         end
                end
                if (ns != 2) begin
                    if (m_dir == 0) begin
                        if (m_x + M_VX >= 1000) begin m_x = 1000; m_dir = 1; m_wh = 1; end
                        else m_x = m_x + M_VX;
                    end else begin
                        if (m_x < 8 + M_VX) begin m_x = 8; m_dir = 0; m_wh = 1; end
                        else m_x = m_x - M_VX;
                    end
                end
                m_y = ny; m_vy = nv; m_st = ns;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid != 0) begin
            chk("A_x",    int'(ax),     m_x);
            chk("A_y",    int'(ay),     m_y);
            chk("A_rest", int'(a_rest), int'(m_st == 2));
            chk("A_fhit", int'(a_fh),   m_fh);
            chk("A_whit", int'(a_wh),   m_wh);
        end
    end

    task automatic wait_ticks(input int target);
        int n = 0;
        while (m_ticks < target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (m_ticks < target) chk("tick_timeout", m_ticks, target);
    endtask

    int t0;

    initial begin
        rst_n = 1'b0; launch = 1'b0; pause = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_x", int'(ax), 504);
        chk("rst_y", int'(ay), 0);
        chk("rst_rest", int'(a_rest), 0);
        chk("rst_fhit", int'(a_fh), 0);
        chk("rst_whit", int'(a_wh), 0);
        chk("rstB_x", int'(bx), 996);
        chk("rstB_y", int'(by), 500);
        rst_n = 1'b1;

        wait_ticks(1);
        chk("A_y_t1", int'(ay), 1);
        chk("B_x_t1", int'(bx), 996);
        chk("B_rest_t1", int'(b_rest), 1);
        chk("B_fhit_t1", int'(b_fh), 1);
        chk("C_x_t1", int'(cx), 998);
        chk("C_y_t1", int'(cy), 0);
        wait_ticks(2);
        chk("C_x_t2", int'(cx), 1000);
        chk("C_whit_t2", int'(c_wh), 1);
        chk("C_y_t2", int'(cy), 1);
        wait_ticks(3);
        chk("C_x_t3", int'(cx), 998);
        chk("C_whit_t3", int'(c_wh), 0);
        chk("C_y_t3", int'(cy), 3);
        chk("B_x_t3", int'(bx), 996);

        wait_ticks(10);
        chk("A_y_t10", int'(ay), 55);
        @(negedge clk);
        pause = 1'b1;
        repeat (20) @(negedge clk);
        chk("pause_y", int'(ay), 55);
        pause = 1'b0;

        wait_ticks(31);
        chk("A_y_t31", int'(ay), 496);
        wait_ticks(32);
        chk("A_y_t32", int'(ay), 500);
        chk("A_fhit_t32", int'(a_fh), 1);
        @(negedge clk);
        chk("A_fhit_after", int'(a_fh), 0);
        wait_ticks(48);
        chk("A_y_t48", int'(ay), 364);

        for (int i = 0; i < 4000 && m_st != 2; i++) @(negedge clk);
        chk("rest_reached", int'(a_rest), 1);
        chk("rest_y", int'(ay), 500);
        repeat (50 * TD) @(negedge clk);
        chk("rest_hold_y", int'(ay), 500);
        chk("rest_hold_flag", int'(a_rest), 1);

        launch = 1'b1;
        @(negedge clk);
        launch = 1'b0;
        chk("launch_rest", int'(a_rest), 0);
        chk("launch_y", int'(ay), 500);
        t0 = m_ticks;
        wait_ticks(t0 + 16);
        chk("ceiling_y", int'(ay), 0);
        wait_ticks(t0 + 18);
        chk("refall_y", int'(ay), 1);
        wait_ticks(t0 + 25);
        chk("refall_y8", int'(ay), 36);

        pause = 1'b1;
        launch = 1'b1;
        @(negedge clk);
        launch = 1'b0;
        repeat (5) @(negedge clk);
        chk("paused_rise_y", int'(ay), 36);
        rst_n = 1'b0;
        launch = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        launch = 1'b0;
        chk("rst2_x", int'(ax), 504);
        chk("rst2_y", int'(ay), 0);
        chk("rst2_rest", int'(a_rest), 0);
        repeat (10) @(negedge clk);
        chk("rst2_paused_y", int'(ay), 0);
        pause = 1'b0;
        wait_ticks(1);
        chk("rst2_t1_y", int'(ay), 1);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
